// File: rtl/seg_display_scan.sv
// -----------------------------------------------------------------------------
// seg_display_scan
//
// Two-digit multiplexed seven-segment driver for common-anode displays.
// A load strobe captures a ten-digit and a one-digit nibble. Each nibble is
// decoded as hex 0-F into active-low segments. The two digits are scanned in
// the order ONE -> GAP1 -> TEN -> GAP0, with a one-cycle blank gap between
// the digit slots so that no ghosting can occur. A one-cycle "shown" pulse
// reports that a newly loaded value has been on the display for one complete
// scan frame.
//
// Parameters
//   REFRESH_DIV    cycles each digit stays enabled per frame (2..65535)
//   BLANK_LEADING  1: a ten digit of zero is blanked (anodes off)
//
// Ports
//   clk        in   system clock, rising edge
//   reset      in   asynchronous active-low reset
//   load       in   capture strobe for digit_ten / digit_one
//   digit_ten  in   [3:0] ten-digit nibble
//   digit_one  in   [3:0] one-digit nibble
//   seg        out  [6:0] {g,f,e,d,c,b,a}, active-low segments (registered)
//   an         out  [1:0] active-low anodes, an[0]=one digit, an[1]=ten digit
//   shown      out  one-cycle pulse, pending load displayed for a full frame
// -----------------------------------------------------------------------------
module seg_display_scan #(
    parameter int REFRESH_DIV   = 16,
    parameter bit BLANK_LEADING = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [3:0] digit_ten,
    input  logic [3:0] digit_one,
    output logic [6:0] seg,
    output logic [1:0] an,
    output logic       shown
);

    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(REFRESH_DIV - 1);

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [1:0] AN_OFF    = 2'b11;
    localparam logic [1:0] AN_ONE    = 2'b10;
    localparam logic [1:0] AN_TEN    = 2'b01;

    typedef enum logic [1:0] {
        ST_ONE  = 2'd0,
        ST_GAP1 = 2'd1,
        ST_TEN  = 2'd2,
        ST_GAP0 = 2'd3
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [3:0]       r_latchTen;
    logic [3:0]       r_latchOne;
    logic             r_pending;
    logic             r_frameArmed;
    logic [6:0]       r_seg;
    logic [1:0]       r_an;
    logic             r_shown;

    state_t           w_nextState;
    logic [CNT_W-1:0] w_nextCnt;
    logic [6:0]       w_nextSeg;
    logic [1:0]       w_nextAn;
    logic             w_enterOne;

    // Hex to active-low segment pattern, bit order {g,f,e,d,c,b,a}.
    function automatic logic [6:0] decHex(input logic [3:0] value);
        logic [6:0] pattern;
        case (value)
            4'h0: pattern = 7'b1000000;
            4'h1: pattern = 7'b1111001;
            4'h2: pattern = 7'b0100100;
            4'h3: pattern = 7'b0110000;
            4'h4: pattern = 7'b0011001;
            4'h5: pattern = 7'b0010010;
            4'h6: pattern = 7'b0000010;
            4'h7: pattern = 7'b1111000;
            4'h8: pattern = 7'b0000000;
            4'h9: pattern = 7'b0010000;
            4'hA: pattern = 7'b0001000;
            4'hB: pattern = 7'b0000011;
            4'hC: pattern = 7'b1000110;
            4'hD: pattern = 7'b0100001;
            4'hE: pattern = 7'b0000110;
            default: pattern = 7'b0001110;
        endcase
        return pattern;
    endfunction

    // Scan sequencing. The slot counter restarts at zero on every state
    // change. The gap states always last exactly one cycle.
    always_comb begin
        w_nextState = r_state;
        w_nextCnt   = r_cnt + CNT_W'(1);
        case (r_state)
            ST_ONE: begin
                if (r_cnt == LAST_CNT) begin
                    w_nextState = ST_GAP1;
                    w_nextCnt   = '0;
                end
            end
            ST_GAP1: begin
                w_nextState = ST_TEN;
                w_nextCnt   = '0;
            end
            ST_TEN: begin
                if (r_cnt == LAST_CNT) begin
                    w_nextState = ST_GAP0;
                    w_nextCnt   = '0;
                end
            end
            default: begin
                w_nextState = ST_ONE;
                w_nextCnt   = '0;
            end
        endcase
    end

    // The edge that leaves GAP0 is also the edge that starts a new frame.
    assign w_enterOne = (r_state == ST_GAP0);

    // The outputs are computed from the state being entered. This lets the
    // registered anodes and segments change on the same edge as the state.
    // The segments are refreshed every cycle from the current latch, so a
    // new load appears one edge after it is captured.
    always_comb begin
        w_nextSeg = SEG_BLANK;
        w_nextAn  = AN_OFF;
        case (w_nextState)
            ST_ONE: begin
                w_nextAn  = AN_ONE;
                w_nextSeg = decHex(r_latchOne);
            end
            ST_TEN: begin
                if (!(BLANK_LEADING && (r_latchTen == 4'h0))) begin
                    w_nextAn  = AN_TEN;
                    w_nextSeg = decHex(r_latchTen);
                end
            end
            default: begin
                w_nextAn  = AN_OFF;
                w_nextSeg = SEG_BLANK;
            end
        endcase
    end

    // State, slot counter and the registered display drive.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_ONE;
            r_cnt   <= '0;
            r_seg   <= 7'b1000000;
            r_an    <= AN_ONE;
        end else begin
            r_state <= w_nextState;
            r_cnt   <= w_nextCnt;
            r_seg   <= w_nextSeg;
            r_an    <= w_nextAn;
        end
    end

    // Data latch and shown tracking. "pending" marks a load that no frame
    // has adopted yet. At each frame start it moves into "frameArmed". A load
    // on that same edge stays pending for the following frame. When the armed
    // frame finishes, the frame-start edge emits shown.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_latchTen   <= 4'h0;
            r_latchOne   <= 4'h0;
            r_pending    <= 1'b0;
            r_frameArmed <= 1'b0;
            r_shown      <= 1'b0;
        end else begin
            if (load) begin
                r_latchTen <= digit_ten;
                r_latchOne <= digit_one;
            end
            if (load) begin
                r_pending <= 1'b1;
            end else if (w_enterOne) begin
                r_pending <= 1'b0;
            end
            if (w_enterOne) begin
                r_shown      <= r_frameArmed;
                r_frameArmed <= r_pending;
            end else begin
                r_shown <= 1'b0;
            end
        end
    end

    assign seg   = r_seg;
    assign an    = r_an;
    assign shown = r_shown;

endmodule

// File: tb/tb_seg_display_scan.sv
// -----------------------------------------------------------------------------
// tb_seg_display_scan
//
// Scoreboard bench for seg_display_scan with REFRESH_DIV=4, so one frame is
// 10 cycles. Two instances share the stimulus: "dut" blanks a leading zero
// and "dut0" does not. Expected display values and shown-pulse cycles are
// worked out by hand and queued when each stimulus is issued. A monitor
// process on the falling edge pops and compares them.
//
// Cycle numbering: cyc counts rising edges. Relative cycle 0 is the period
// between reset release and the first rising edge, which is the first ONE
// cycle. Frame position p = rel % 10 gives 0-3 ONE, 4 GAP1, 5-8 TEN, 9 GAP0.
// -----------------------------------------------------------------------------
module tb_seg_display_scan;

    localparam logic [6:0] BLANK = 7'b1111111;

    logic       clk;
    logic       reset;
    logic       load;
    logic [3:0] digit_ten;
    logic [3:0] digit_one;
    logic [6:0] seg;
    logic [1:0] an;
    logic       shown;
    logic [6:0] seg0;
    logic [1:0] an0;
    logic       shown0;

    int cyc    = 0;
    int checks = 0;
    int errors = 0;

    typedef struct {
        int         cyc;
        int         inst;
        logic [1:0] an;
        logic [6:0] seg;
    } dispExp_t;

    dispExp_t dispQ[$];
    int       shownQ[$];

    seg_display_scan #(.REFRESH_DIV(4), .BLANK_LEADING(1'b1)) dut (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .digit_ten (digit_ten),
        .digit_one (digit_one),
        .seg       (seg),
        .an        (an),
        .shown     (shown)
    );

    seg_display_scan #(.REFRESH_DIV(4), .BLANK_LEADING(1'b0)) dut0 (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .digit_ten (digit_ten),
        .digit_one (digit_one),
        .seg       (seg0),
        .an        (an0),
        .shown     (shown0)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Compare one queued display expectation against its instance.
    task automatic checkOutput(input dispExp_t e);
        logic [1:0] actAn;
        logic [6:0] actSeg;
        actAn  = (e.inst == 0) ? an  : an0;
        actSeg = (e.inst == 0) ? seg : seg0;
        checks++;
        if (e.cyc != cyc || actAn !== e.an || actSeg !== e.seg) begin
            errors++;
            $display("[TB] FAIL display cyc=%0d inst=%0d: got an=%b seg=%b (at cyc %0d), want an=%b seg=%b",
                     e.cyc, e.inst, actAn, actSeg, cyc, e.an, e.seg);
        end
    endtask

    // Monitor: display expectations due this cycle, plus the shown pulse
    // of both instances, which must fire only on the queued cycles.
    always @(negedge clk) begin
        bit expShown;
        for (int i = dispQ.size() - 1; i >= 0; i--) begin
            if (dispQ[i].cyc <= cyc) begin
                checkOutput(dispQ[i]);
                dispQ.delete(i);
            end
        end
        expShown = 1'b0;
        if (shownQ.size() > 0 && shownQ[0] == cyc) begin
            expShown = 1'b1;
            void'(shownQ.pop_front());
        end
        if (expShown || shown !== 1'b0) begin
            checks++;
            if (shown !== expShown) begin
                errors++;
                $display("[TB] FAIL shown inst=0 cyc=%0d: got %b, want %b", cyc, shown, expShown);
            end
        end
        if (expShown || shown0 !== 1'b0) begin
            checks++;
            if (shown0 !== expShown) begin
                errors++;
                $display("[TB] FAIL shown inst=1 cyc=%0d: got %b, want %b", cyc, shown0, expShown);
            end
        end
    end

    task automatic waitUntil(input int absCyc);
        while (cyc < absCyc) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic pushDisp(input int c, input int inst, input logic [1:0] a, input logic [6:0] s);
        dispExp_t e;
        e.cyc  = c;
        e.inst = inst;
        e.an   = a;
        e.seg  = s;
        dispQ.push_back(e);
    endtask

    // One full frame: 4 ONE cycles, GAP1, 4 TEN cycles, GAP0.
    task automatic expectFrame(input int start, input int inst, input logic [6:0] oneSeg,
                               input logic [1:0] tenAn, input logic [6:0] tenSeg);
        for (int p = 0; p < 10; p++) begin
            if (p < 4)       pushDisp(start + p, inst, 2'b10, oneSeg);
            else if (p == 4) pushDisp(start + p, inst, 2'b11, BLANK);
            else if (p < 9)  pushDisp(start + p, inst, tenAn, tenSeg);
            else             pushDisp(start + p, inst, 2'b11, BLANK);
        end
    endtask

    // Raise load with the given nibbles during cycle absCyc. The values are
    // captured on the edge that ends that cycle.
    task automatic applyStimulus(input int absCyc, input logic [3:0] ten, input logic [3:0] one);
        waitUntil(absCyc);
        load      = 1'b1;
        digit_ten = ten;
        digit_one = one;
        waitUntil(absCyc + 1);
        load      = 1'b0;
    endtask

    initial begin
        int b;
        int b2;
        reset     = 1'b1;
        load      = 1'b0;
        digit_ten = 4'h0;
        digit_one = 4'h0;
        #1 reset  = 1'b0;

        // Idle after reset: ONE shows 0, and the blanked leading zero turns
        // the TEN slot fully off. The unblanked instance shows 0 on an=01.
        b = 3;
        expectFrame(b,      0, 7'b1000000, 2'b11, BLANK);
        expectFrame(b + 10, 0, 7'b1000000, 2'b11, BLANK);
        expectFrame(b,      1, 7'b1000000, 2'b01, 7'b1000000);
        expectFrame(b + 10, 1, 7'b1000000, 2'b01, 7'b1000000);
        waitUntil(b);
        reset = 1'b1;

        // Load 4/2 during GAP1 of frame 2. Frames 3 and 4 show it. The
        // shown pulse comes after frame 3, the first frame that started
        // after the load.
        expectFrame(b + 30, 0, 7'b0100100, 2'b01, 7'b0011001);
        expectFrame(b + 40, 0, 7'b0100100, 2'b01, 7'b0011001);
        shownQ.push_back(b + 40);
        applyStimulus(b + 24, 4'h4, 4'h2);

        // Back-to-back loads 3F then A7 inside a ONE slot. Each one reaches
        // seg one edge after capture, and the last load wins.
        pushDisp(b + 51, 0, 2'b10, 7'b0100100);
        pushDisp(b + 52, 0, 2'b10, 7'b0001110);
        pushDisp(b + 53, 0, 2'b10, 7'b1111000);
        expectFrame(b + 60, 0, 7'b1111000, 2'b01, 7'b0001000);
        expectFrame(b + 70, 0, 7'b1111000, 2'b01, 7'b0001000);
        shownQ.push_back(b + 70);
        applyStimulus(b + 50, 4'h3, 4'hF);
        applyStimulus(b + 51, 4'hA, 4'h7);

        // Load 1/5 on the GAP0->ONE edge. The first ONE cycle still shows
        // the old 7. There is no shown at b+90, only at b+100.
        pushDisp(b + 80, 0, 2'b10, 7'b1111000);
        pushDisp(b + 81, 0, 2'b10, 7'b0010010);
        expectFrame(b + 90, 0, 7'b0010010, 2'b01, 7'b1111001);
        shownQ.push_back(b + 100);
        applyStimulus(b + 79, 4'h1, 4'h5);

        // Load 9/8 to make it pending, then reset mid-TEN. The outputs return
        // to their reset values at once. The latches are cleared and no shown
        // pulse follows.
        applyStimulus(b + 104, 4'h9, 4'h8);
        waitUntil(b + 106);
        pushDisp(b + 106, 0, 2'b10, 7'b1000000);
        pushDisp(b + 106, 1, 2'b10, 7'b1000000);
        pushDisp(b + 107, 0, 2'b10, 7'b1000000);
        reset = 1'b0;
        waitUntil(b + 108);
        b2 = b + 108;
        expectFrame(b2,      0, 7'b1000000, 2'b11, BLANK);
        expectFrame(b2 + 10, 0, 7'b1000000, 2'b11, BLANK);
        expectFrame(b2,      1, 7'b1000000, 2'b01, 7'b1000000);
        expectFrame(b2 + 10, 1, 7'b1000000, 2'b01, 7'b1000000);
        reset = 1'b1;
        waitUntil(b2 + 26);

        foreach (dispQ[i]) begin
            checks++;
            errors++;
            $display("[TB] FAIL display cyc=%0d inst=%0d never compared: want an=%b seg=%b",
                     dispQ[i].cyc, dispQ[i].inst, dispQ[i].an, dispQ[i].seg);
        end
        foreach (shownQ[i]) begin
            checks++;
            errors++;
            $display("[TB] FAIL shown pulse due at cyc=%0d: got none, want 1", shownQ[i]);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
